// File: rtl/accumulator_access_scheduler_pkg.sv
// Shared types and constants for the accumulator access scheduler.
// Status bit positions match the accumulator's status port.
package accumulator_access_scheduler_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP,
      CLEAR
   } state_e;

   localparam int STATUS_WIDTH     = 5;
   localparam int STATUS_CARRY     = 4;
   localparam int STATUS_AT_MAX    = 3;
   localparam int STATUS_OVER_MAX  = 2;
   localparam int STATUS_AT_MIN    = 1;
   localparam int STATUS_UNDER_MIN = 0;

endpackage

// File: rtl/accumulator_access_scheduler_arbiter.sv
// Combinational round-robin arbiter: the search starts at pointer_i and wraps.
// advance_i enables arbitration for the current cycle; with it low no grant is produced.
module arbiter_round_robin #(
   parameter int REQUESTERS = 4
) (
   input  logic [REQUESTERS-1:0]         requests_i,
   input  logic [$clog2(REQUESTERS)-1:0] pointer_i,
   input  logic                          advance_i,
   output logic [REQUESTERS-1:0]         grant_o,
   output logic                          valid_o
);

   localparam int PW = $clog2(REQUESTERS);

   logic [PW-1:0] idx;

   always_comb begin
      grant_o = '0;
      valid_o = 1'b0;
      idx     = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         idx = PW'((int'(pointer_i) + k) % REQUESTERS);
         if (advance_i && !valid_o && requests_i[idx]) begin
            grant_o[idx] = 1'b1;
            valid_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/accumulator_access_scheduler.sv
// Shares one pipelined saturating accumulator among several clients, one operation at a time,
// with host clears and a timeout guarding against a lost update strobe.
module accumulator_access_scheduler
   import accumulator_access_scheduler_pkg::*;
#(
   parameter int REQUESTERS     = 4,
   parameter int WORD_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             clock,
   input  logic                             clear_n,
   input  logic [REQUESTERS-1:0]            req_valid,
   output logic [REQUESTERS-1:0]            req_ready,
   input  logic [REQUESTERS-1:0]            req_load,
   input  logic [REQUESTERS*WORD_WIDTH-1:0] req_value,
   output logic [REQUESTERS-1:0]            rsp_valid,
   output logic [WORD_WIDTH-1:0]            rsp_value,
   output logic [STATUS_WIDTH-1:0]          rsp_status,
   output logic                             rsp_timeout,
   input  logic                             clear_request,
   output logic                             clear_done,
   output logic [WORD_WIDTH-1:0]            acc_increment,
   output logic [WORD_WIDTH-1:0]            acc_load_value,
   output logic                             acc_increment_valid,
   output logic                             acc_load_valid,
   output logic                             acc_clear,
   input  logic [WORD_WIDTH-1:0]            acc_value,
   input  logic                             acc_updated,
   input  logic [STATUS_WIDTH-1:0]          acc_status,
   output logic                             timeout_sticky
);

   localparam int PW = $clog2(REQUESTERS);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   state_e                  state_q, state_d;
   logic [PW-1:0]           grant_q, grant_d;
   logic [PW-1:0]           pointer_q, pointer_d;
   logic [CW-1:0]           count_q, count_d;
   logic [WORD_WIDTH-1:0]   value_q, value_d;
   logic [STATUS_WIDTH-1:0] status_q, status_d;
   logic                    timeout_q, timeout_d;
   logic                    sticky_q, sticky_d;

   logic [REQUESTERS-1:0]   arbGrant;
   logic                    arbValid;
   logic [PW-1:0]           arbIndex;
   logic [WORD_WIDTH-1:0]   reqWord [REQUESTERS];

   arbiter_round_robin #(
      .REQUESTERS (REQUESTERS)
   ) u_arbiter (
      .requests_i (req_valid),
      .pointer_i  (pointer_q),
      .advance_i  ((state_q == IDLE) && !clear_request),
      .grant_o    (arbGrant),
      .valid_o    (arbValid)
   );

   always_comb begin
      arbIndex = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         if (arbGrant[k]) begin
            arbIndex = PW'(k);
         end
      end
   end

   always_comb begin
      for (int k = 0; k < REQUESTERS; k++) begin
         reqWord[k] = req_value[k*WORD_WIDTH +: WORD_WIDTH];
      end
   end

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         pointer_q <= '0;
         count_q   <= '0;
         value_q   <= '0;
         status_q  <= '0;
         timeout_q <= 1'b0;
         sticky_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         pointer_q <= pointer_d;
         count_q   <= count_d;
         value_q   <= value_d;
         status_q  <= status_d;
         timeout_q <= timeout_d;
         sticky_q  <= sticky_d;
      end
   end

   // Clear wins over client traffic in IDLE; acc_updated is only looked at in WAIT,
   // so stray strobes elsewhere have no effect.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      pointer_d = pointer_q;
      count_d   = count_q;
      value_d   = value_q;
      status_d  = status_q;
      timeout_d = timeout_q;
      sticky_d  = sticky_q;
      case (state_q)
         IDLE: begin
            if (clear_request) begin
               state_d = CLEAR;
            end else if (arbValid) begin
               grant_d = arbIndex;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            pointer_d = (grant_q == PW'(REQUESTERS - 1)) ? '0 : grant_q + 1'b1;
            count_d   = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            if (acc_updated) begin
               value_d   = acc_value;
               status_d  = acc_status;
               timeout_d = 1'b0;
               state_d   = RESP;
            end else begin
               count_d = count_q + 1'b1;
               if (count_q + 1'b1 == CW'(TIMEOUT_CYCLES)) begin
                  value_d   = '0;
                  status_d  = '0;
                  timeout_d = 1'b1;
                  sticky_d  = 1'b1;
                  state_d   = RESP;
               end
            end
         end
         RESP:    state_d = IDLE;
         CLEAR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // acc_clear follows clear_n directly so the accumulator is cleared alongside the controller.
   always_comb begin
      req_ready           = '0;
      rsp_valid           = '0;
      rsp_value           = '0;
      rsp_status          = '0;
      rsp_timeout         = 1'b0;
      clear_done          = 1'b0;
      acc_increment       = '0;
      acc_load_value      = '0;
      acc_increment_valid = 1'b0;
      acc_load_valid      = 1'b0;
      acc_clear           = ~clear_n;
      case (state_q)
         ISSUE: begin
            req_ready[grant_q] = 1'b1;
            if (req_load[grant_q]) begin
               acc_load_value = reqWord[grant_q];
               acc_load_valid = 1'b1;
            end else begin
               acc_increment       = reqWord[grant_q];
               acc_increment_valid = 1'b1;
            end
         end
         RESP: begin
            rsp_valid[grant_q] = 1'b1;
            rsp_value          = value_q;
            rsp_status         = status_q;
            rsp_timeout        = timeout_q;
         end
         CLEAR: begin
            acc_clear  = 1'b1;
            clear_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign timeout_sticky = sticky_q;

endmodule

// File: tb/tb_accumulator_access_scheduler.sv
// Testbench for accumulator_access_scheduler: a behavioural saturating accumulator with latency L
// sits on the accumulator port, and expected results come from a running reference value.
module tb_accumulator_access_scheduler;
   import accumulator_access_scheduler_pkg::*;

   localparam int N         = 4;
   localparam int W         = 16;
   localparam int T         = 16;
   localparam int L         = 3;
   localparam int MAX_LIMIT = 100;
   localparam int MIN_LIMIT = -100;

   logic                    clock;
   logic                    clearN;
   logic [N-1:0]            reqValid;
   logic [N-1:0]            reqReady;
   logic [N-1:0]            reqLoad;
   logic [N*W-1:0]          reqValue;
   logic [N-1:0]            rspValid;
   logic [W-1:0]            rspValue;
   logic [STATUS_WIDTH-1:0] rspStatus;
   logic                    rspTimeout;
   logic                    clearRequest;
   logic                    clearDone;
   logic [W-1:0]            accIncrement;
   logic [W-1:0]            accLoadValue;
   logic                    accIncrementValid;
   logic                    accLoadValid;
   logic                    accClear;
   logic [W-1:0]            accValue;
   logic                    accUpdated;
   logic [STATUS_WIDTH-1:0] accStatus;
   logic                    timeoutSticky;

   bit           suppress;
   bit           stray;
   int           checks;
   int           errors;
   logic [W-1:0] refAcc;

   accumulator_access_scheduler #(
      .REQUESTERS     (N),
      .WORD_WIDTH     (W),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clock               (clock),
      .clear_n             (clearN),
      .req_valid           (reqValid),
      .req_ready           (reqReady),
      .req_load            (reqLoad),
      .req_value           (reqValue),
      .rsp_valid           (rspValid),
      .rsp_value           (rspValue),
      .rsp_status          (rspStatus),
      .rsp_timeout         (rspTimeout),
      .clear_request       (clearRequest),
      .clear_done          (clearDone),
      .acc_increment       (accIncrement),
      .acc_load_value      (accLoadValue),
      .acc_increment_valid (accIncrementValid),
      .acc_load_valid      (accLoadValid),
      .acc_clear           (accClear),
      .acc_value           (accValue),
      .acc_updated         (accUpdated),
      .acc_status          (accStatus),
      .timeout_sticky      (timeoutSticky)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Signed saturating step of the accumulator: returns {status, value}.
   function automatic logic [20:0] accStep(input logic [W-1:0] cur, input bit ld, input logic [W-1:0] opnd);
      int          raw;
      int          res;
      logic [W:0]  usum;
      logic [4:0]  st;
      st = '0;
      if (ld) begin
         raw = int'($signed(opnd));
      end else begin
         raw  = int'($signed(cur)) + int'($signed(opnd));
         usum = {1'b0, cur} + {1'b0, opnd};
         st[STATUS_CARRY] = usum[W];
      end
      if (raw > MAX_LIMIT) begin
         res = MAX_LIMIT;
         st[STATUS_OVER_MAX] = 1'b1;
      end else if (raw < MIN_LIMIT) begin
         res = MIN_LIMIT;
         st[STATUS_UNDER_MIN] = 1'b1;
      end else begin
         res = raw;
      end
      st[STATUS_AT_MAX] = (res == MAX_LIMIT);
      st[STATUS_AT_MIN] = (res == MIN_LIMIT);
      return {st, W'(res)};
   endfunction

   // Behavioural accumulator with L cycles from operation pulse to update strobe.
   logic [L-1:0]  pipeValid;
   logic [W-1:0]  pipeValue  [L];
   logic [4:0]    pipeStatus [L];
   logic [W-1:0]  envAcc;
   logic [20:0]   envNext;
   logic          envOp;

   assign envOp      = (accIncrementValid | accLoadValid) & ~suppress;
   assign envNext    = accStep(envAcc, accLoadValid, accLoadValid ? accLoadValue : accIncrement);
   assign accUpdated = pipeValid[L-1] | stray;
   assign accValue   = pipeValue[L-1];
   assign accStatus  = pipeStatus[L-1];

   always @(posedge clock) begin
      if (accClear) begin
         envAcc    <= '0;
         pipeValid <= '0;
      end else begin
         pipeValid     <= {pipeValid[L-2:0], envOp};
         pipeValue[0]  <= envNext[W-1:0];
         pipeStatus[0] <= envNext[20:16];
         for (int k = 1; k < L; k++) begin
            pipeValue[k]  <= pipeValue[k-1];
            pipeStatus[k] <= pipeStatus[k-1];
         end
         if (envOp) begin
            envAcc <= envNext[W-1:0];
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Raise one request in IDLE and follow it until its response (bounded).
   task automatic applyStimulus(input int c, input bit ld, input logic [W-1:0] v,
                                output int latency, output int pulses,
                                output logic [W-1:0] opSeen, output bit gotRsp);
      int cyc;
      @(negedge clock);
      reqValid[c]           = 1'b1;
      reqLoad[c]            = ld;
      reqValue[c*W +: W]    = v;
      cyc    = 0;
      pulses = 0;
      opSeen = '0;
      gotRsp = 1'b0;
      while (!gotRsp && cyc < 100) begin
         @(negedge clock);
         cyc++;
         if (accIncrementValid || accLoadValid) begin
            pulses++;
            opSeen = ld ? accLoadValue : accIncrement;
         end
         if (reqReady[c]) reqValid[c] = 1'b0;
         if (rspValid != '0) gotRsp = 1'b1;
      end
      reqValid[c] = 1'b0;
      latency     = cyc;
   endtask

   task automatic serveOne(input string tag, input int c, input bit ld, input logic [W-1:0] v,
                           input bit expTimeout);
      int           lat;
      int           pulses;
      logic [W-1:0] opSeen;
      bit           got;
      logic [20:0]  e;
      applyStimulus(c, ld, v, lat, pulses, opSeen, got);
      if (expTimeout) begin
         e = '0;
      end else begin
         e      = accStep(refAcc, ld, v);
         refAcc = e[W-1:0];
      end
      checkOutput({tag, " response seen"}, 32'(got), 32'd1);
      checkOutput({tag, " latency"}, 32'(lat), expTimeout ? 32'(T + 2) : 32'(L + 2));
      checkOutput({tag, " op pulses"}, 32'(pulses), 32'd1);
      checkOutput({tag, " operand"}, 32'(opSeen), 32'(v));
      checkOutput({tag, " rspValid"}, 32'(rspValid), 32'(1) << c);
      checkOutput({tag, " rspValue"}, 32'(rspValue), 32'(e[W-1:0]));
      checkOutput({tag, " rspStatus"}, 32'(rspStatus), 32'(e[20:16]));
      checkOutput({tag, " rspTimeout"}, 32'(rspTimeout), 32'(expTimeout));
   endtask

   task automatic clearSequence(input string tag);
      int cyc;
      bit seen;
      @(negedge clock);
      clearRequest = 1'b1;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 20) begin
         @(negedge clock);
         cyc++;
         if (clearDone) begin
            seen = 1'b1;
            checkOutput({tag, " accClear with done"}, 32'(accClear), 32'd1);
            clearRequest = 1'b0;
         end
      end
      clearRequest = 1'b0;
      checkOutput({tag, " clearDone seen"}, 32'(seen), 32'd1);
      checkOutput({tag, " clear latency"}, 32'(cyc), 32'd1);
      @(negedge clock);
      checkOutput({tag, " clearDone one cycle"}, 32'(clearDone), 32'd0);
      refAcc = '0;
   endtask

   initial begin : main
      int           order [$];
      int           rspCyc [$];
      logic [W-1:0] rspVals [$];
      int           quota [N];
      int           cyc;
      int           nResp;
      int           extraDone;
      int           firstGrant;
      bit           got;
      logic [20:0]  e;
      logic [W-1:0] respVal [2];

      checks = 0; errors = 0;
      suppress = 1'b0; stray = 1'b0;
      clearN = 1'b0; reqValid = '0; reqLoad = '0; reqValue = '0; clearRequest = 1'b0;
      refAcc = '0;

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("reset accClear", 32'(accClear), 32'd1);
      checkOutput("reset reqReady", 32'(reqReady), 32'd0);
      checkOutput("reset rspValid", 32'(rspValid), 32'd0);
      checkOutput("reset sticky", 32'(timeoutSticky), 32'd0);
      checkOutput("reset clearDone", 32'(clearDone), 32'd0);
      clearN = 1'b1;
      #1;
      checkOutput("released accClear", 32'(accClear), 32'd0);

      // Fairness: all clients hold valid, two increments of 1 each
      @(negedge clock);
      for (int c = 0; c < N; c++) begin
         reqValid[c] = 1'b1; reqLoad[c] = 1'b0; reqValue[c*W +: W] = 16'd1; quota[c] = 2;
      end
      cyc = 0; nResp = 0;
      while (nResp < 8 && cyc < 300) begin
         @(negedge clock);
         cyc++;
         for (int c = 0; c < N; c++) begin
            if (reqReady[c]) begin
               order.push_back(c);
               quota[c]--;
               if (quota[c] == 0) reqValid[c] = 1'b0;
            end
         end
         if (rspValid != '0) begin
            rspCyc.push_back(cyc);
            rspVals.push_back(rspValue);
            nResp++;
         end
      end
      reqValid = '0;
      checkOutput("fair grants", 32'(order.size()), 32'd8);
      checkOutput("fair responses", 32'(nResp), 32'd8);
      for (int k = 0; k < order.size() && k < 8; k++)
         checkOutput($sformatf("fair order %0d", k), 32'(order[k]), 32'(k % N));
      for (int k = 0; k < rspVals.size(); k++) begin
         refAcc = accStep(refAcc, 1'b0, 16'd1) >> 0;
         checkOutput($sformatf("fair value %0d", k), 32'(rspVals[k]), 32'(refAcc));
         if (k > 0)
            checkOutput($sformatf("fair spacing %0d", k), 32'(rspCyc[k] - rspCyc[k-1]), 32'(L + 3));
      end

      // Clear, then single increment from zero
      clearSequence("clear");
      serveOne("single inc", 1, 1'b0, 16'd5, 1'b0);

      // Load with saturation
      serveOne("load sat", 2, 1'b1, 16'd200, 1'b0);
      checkOutput("load sat flags", 32'(rspStatus & 5'b01100), 32'b01100);

      // Clear precedence over a simultaneous request
      @(negedge clock);
      clearRequest = 1'b1; reqValid[0] = 1'b1; reqLoad[0] = 1'b0; reqValue[W-1:0] = 16'd7;
      @(negedge clock);
      checkOutput("prec clearDone", 32'(clearDone), 32'd1);
      checkOutput("prec accClear", 32'(accClear), 32'd1);
      checkOutput("prec reqReady", 32'(reqReady), 32'd0);
      clearRequest = 1'b0;
      refAcc = '0;
      cyc = 1; got = 1'b0; extraDone = 0;
      while (!got && cyc < 100) begin
         @(negedge clock);
         cyc++;
         if (reqReady[0]) reqValid[0] = 1'b0;
         if (clearDone) extraDone++;
         if (rspValid != '0) got = 1'b1;
      end
      reqValid[0] = 1'b0;
      e = accStep(refAcc, 1'b0, 16'd7);
      refAcc = e[W-1:0];
      checkOutput("prec single done", 32'(extraDone), 32'd0);
      checkOutput("prec latency", 32'(cyc), 32'(L + 4));
      checkOutput("prec rspValid", 32'(rspValid), 32'b0001);
      checkOutput("prec rspValue", 32'(rspValue), 32'(e[W-1:0]));

      // Timeout with the update strobe withheld, then a normal operation
      suppress = 1'b1;
      serveOne("timeout", 1, 1'b0, 16'd10, 1'b1);
      checkOutput("timeout sticky", 32'(timeoutSticky), 32'd1);
      suppress = 1'b0;
      serveOne("after timeout", 2, 1'b0, 16'd1, 1'b0);
      checkOutput("sticky holds", 32'(timeoutSticky), 32'd1);

      // Randomized traffic
      for (int i = 0; i < 12; i++) begin
         int           rc;
         bit           rl;
         logic [W-1:0] rv;
         rc = int'($urandom_range(0, N - 1));
         rl = ($urandom_range(0, 3) == 0);
         rv = W'(int'($urandom_range(0, 300)) - 150);
         serveOne($sformatf("rand %0d", i), rc, rl, rv, 1'b0);
      end

      // Reset in the middle of WAIT
      @(negedge clock);
      reqValid[2] = 1'b1; reqLoad[2] = 1'b0; reqValue[2*W +: W] = 16'd9;
      cyc = 0;
      while (!reqReady[2] && cyc < 20) begin
         @(negedge clock);
         cyc++;
      end
      checkOutput("midwait issued", 32'(reqReady[2]), 32'd1);
      reqValid[2] = 1'b0;
      @(negedge clock);
      clearN = 1'b0;
      #1;
      checkOutput("midwait accClear", 32'(accClear), 32'd1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         checkOutput("reset no rsp", 32'(rspValid), 32'd0);
         checkOutput("reset accClear held", 32'(accClear), 32'd1);
      end
      checkOutput("reset clears sticky", 32'(timeoutSticky), 32'd0);
      clearN = 1'b1;
      refAcc = '0;
      @(negedge clock);
      stray = 1'b1;
      @(negedge clock);
      stray = 1'b0;
      checkOutput("stray no rsp", 32'(rspValid), 32'd0);
      @(negedge clock);
      checkOutput("stray no rsp later", 32'(rspValid), 32'd0);
      reqValid[0] = 1'b1; reqLoad[0] = 1'b0; reqValue[W-1:0]     = 16'd3;
      reqValid[3] = 1'b1; reqLoad[3] = 1'b0; reqValue[3*W +: W]  = 16'd4;
      firstGrant = -1; nResp = 0; cyc = 0;
      while (nResp < 2 && cyc < 100) begin
         @(negedge clock);
         cyc++;
         for (int c = 0; c < N; c++) begin
            if (reqReady[c]) begin
               if (firstGrant < 0) firstGrant = c;
               reqValid[c] = 1'b0;
            end
         end
         if (rspValid != '0) begin
            respVal[nResp] = rspValue;
            nResp++;
         end
      end
      reqValid = '0;
      checkOutput("post reset first grant", 32'(firstGrant), 32'd0);
      checkOutput("post reset responses", 32'(nResp), 32'd2);
      e = accStep(refAcc, 1'b0, 16'd3);
      refAcc = e[W-1:0];
      checkOutput("post reset value 0", 32'(respVal[0]), 32'(refAcc));
      e = accStep(refAcc, 1'b0, 16'd4);
      refAcc = e[W-1:0];
      checkOutput("post reset value 1", 32'(respVal[1]), 32'(refAcc));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
